// File: rtl/async_fifo.sv
// Same-clock FIFO of DEPTH words with registered read data, valid one edge after an accepted read.
// Full rejects writes (overflow pulse) and empty rejects reads (underflow pulse); flags come from registered pointers only.
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH   = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_LVL  = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // The pointer MSB is a wrap bit: equal low bits with differing MSBs means full.
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                        (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign data_out     = data_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  always_comb begin
    wr_acc   = wr_en && !full;
    rd_acc   = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    ovf_d    = wr_en && full;
    udf_d    = rd_en && empty;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      data_d   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: a hand-computed vector table plus queue-modelled corner sequences.
module tb_async_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int total;
  int bad;

  async_fifo #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .AF_LEVEL(14),
    .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .data_in(data_in),
    .data_out(data_out),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t       tbl [9];
  logic [7:0] mq [$];
  logic [7:0] m_dout;

  task automatic chk(input string nm, input string f, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s %s: got=%0h want=%0h", nm, f, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [7:0] e_dout, input logic [4:0] e_cnt,
                           input logic e_full, input logic e_empty, input logic e_af,
                           input logic e_ae, input logic e_ovf, input logic e_udf);
    chk(nm, "data_out", data_out, e_dout);
    chk(nm, "count", {3'b0, count}, {3'b0, e_cnt});
    chk(nm, "full", {7'b0, full}, {7'b0, e_full});
    chk(nm, "empty", {7'b0, empty}, {7'b0, e_empty});
    chk(nm, "almost_full", {7'b0, almost_full}, {7'b0, e_af});
    chk(nm, "almost_empty", {7'b0, almost_empty}, {7'b0, e_ae});
    chk(nm, "overflow", {7'b0, overflow}, {7'b0, e_ovf});
    chk(nm, "underflow", {7'b0, underflow}, {7'b0, e_udf});
  endtask

  // One clocked operation checked against a queue model of the FIFO.
  task automatic op(input logic w, input logic r, input logic [7:0] d, input string nm);
    int   sz;
    logic e_ovf;
    logic e_udf;
    sz    = mq.size();
    e_ovf = w && (sz == 16);
    e_udf = r && (sz == 0);
    if (r && sz != 0) m_dout = mq.pop_front();
    if (w && sz != 16) mq.push_back(d);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
    sz = mq.size();
    check_all(nm, m_dout, 5'(sz), sz == 16, sz == 0, sz >= 14, sz <= 2, e_ovf, e_udf);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    m_dout  = 8'h00;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;

    //            wr    rd    din    dout   cnt   full  empty af    ae    ovf   udf
    tbl[0] = '{1'b1, 1'b0, 8'hAA, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h55, 8'h00, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h00, 8'hAA, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 8'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 8'h11, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 8'h22, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 8'h00, 8'h22, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      wr_en   = tbl[i].wr;
      rd_en   = tbl[i].rd;
      data_in = tbl[i].din;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].dout, tbl[i].cnt, tbl[i].full, tbl[i].empty,
                tbl[i].af, tbl[i].ae, tbl[i].ovf, tbl[i].udf);
    end
    m_dout = 8'h22;

    // Asynchronous reset in the middle of a clock period with data stored.
    for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 8'h30 + 8'(i), "pre_reset");
    wr_en = 1'b0;
    rd_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    mq.delete();
    m_dout = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill to full, then overflow and its single-cycle pulse.
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(i), "fill");
    op(1'b1, 1'b0, 8'hEE, "overflow");
    op(1'b0, 1'b0, 8'h00, "overflow_clear");

    // Drain in order, then underflow with data_out holding.
    for (int i = 0; i < 16; i++) begin
      op(1'b0, 1'b1, 8'h00, "drain");
      chk("drain_order", "data_out", data_out, 8'(i));
    end
    op(1'b0, 1'b1, 8'h00, "underflow");
    chk("underflow_hold", "data_out", data_out, 8'h0F);
    op(1'b0, 1'b0, 8'h00, "underflow_clear");

    // 20 writes and 20 reads with overlap at half occupancy across the pointer wrap.
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 8'h80 + 8'(i), "wrap_wr");
    for (int i = 8; i < 20; i++) begin
      op(1'b1, 1'b1, 8'h80 + 8'(i), "wrap_both");
      chk("wrap_both_order", "data_out", data_out, 8'h80 + 8'(i - 8));
      chk("wrap_both_stable", "count", {3'b0, count}, 8'd8);
    end
    for (int i = 12; i < 20; i++) begin
      op(1'b0, 1'b1, 8'h00, "wrap_rd");
      chk("wrap_rd_order", "data_out", data_out, 8'h80 + 8'(i));
    end

    // Simultaneous write and read while full: only the read is accepted.
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'h40 + 8'(i), "refill");
    op(1'b1, 1'b1, 8'hEE, "full_both");
    chk("full_both_dout", "data_out", data_out, 8'h40);
    for (int i = 0; i < 15; i++) op(1'b0, 1'b1, 8'h00, "final_drain");
    chk("final_dout", "data_out", data_out, 8'h4F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
